sink_byte_serializer: RTL and testbench

- Sits directly downstream of the network sink stage and consumes its snk word stream (valid/ready).
- Serializes each SNK_WIDTH-bit output word into a byte stream for the host transport TX path (UART/FIFO byte interface), most-significant byte first.
- Holds one word at a time and applies full backpressure in both directions.
- Sustains one word per NUM_BYTES cycles when tx_ready is held high.

---
 rtl/sink_byte_serializer.sv | 134 +++++++++++++
 tb/tb_sink_byte_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sink_byte_serializer.sv
// Serializes SNK_WIDTH-bit sink words into an MSB-first byte stream with valid/ready on both sides.
// Optional macro SINK_ZERO_SKIP_EN: all-zero words are counted and each frame carries a skip-count prefix byte.
module sink_byte_serializer #(
    parameter int SNK_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 snk_valid,
    output logic                 snk_ready,
    input  logic [SNK_WIDTH-1:0] snk,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 busy
);

    localparam int NUM_BYTES = (SNK_WIDTH + 7) / 8;
    localparam int PAD_W     = NUM_BYTES * 8;
`ifdef SINK_ZERO_SKIP_EN
    localparam int FRAME_BYTES = NUM_BYTES + 1;
`else
    localparam int FRAME_BYTES = NUM_BYTES;
`endif
    localparam int SHIFT_W = FRAME_BYTES * 8;
    localparam int IDX_W   = $clog2(FRAME_BYTES + 1);
    localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(FRAME_BYTES - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_ZERO = {SHIFT_W{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_r, state_next_s;
    logic [SHIFT_W-1:0] shift_r, shift_next_s, load_word_s;
    logic [IDX_W-1:0]   idx_r, idx_next_s;
    logic               tx_valid_r, busy_r;
    logic               ready_s, accept_s, load_s, tx_hs_s, last_s;
    logic [PAD_W-1:0]   padded_s;

    assign padded_s = PAD_W'(snk);
    assign last_s   = (idx_r == LAST_IDX);
    assign tx_hs_s  = tx_valid_r & tx_ready;

    // Upstream ready: free in IDLE, and on the last byte it follows tx_ready so words chain without a bubble.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            IDLE:    ready_s = 1'b1;
            SEND:    ready_s = last_s ? tx_ready : 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    assign snk_ready = rst ? 1'b0 : ready_s;
    assign accept_s  = snk_valid & snk_ready;

`ifdef SINK_ZERO_SKIP_EN
    logic [7:0] skip_cnt_r;
    logic       word_zero_s, skip_inc_s, prefix_hs_s;

    assign word_zero_s = (snk == {SNK_WIDTH{1'b0}});
    // A zero word at count 255 is not skipped; it forces out an 0xFF frame that includes itself.
    assign skip_inc_s  = accept_s & word_zero_s & (skip_cnt_r != 8'hFF);
    assign load_s      = accept_s & ~skip_inc_s;
    assign prefix_hs_s = tx_hs_s & (idx_r == IDX_ZERO);
    assign load_word_s = {(word_zero_s ? 8'hFF : skip_cnt_r), padded_s};

    // Skip counter: counts swallowed zero words, cleared once the prefix byte has been taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt_r <= 8'h00;
        end else if (skip_inc_s) begin
            skip_cnt_r <= skip_cnt_r + 8'h01;
        end else if (prefix_hs_s) begin
            skip_cnt_r <= 8'h00;
        end else begin
            skip_cnt_r <= skip_cnt_r;
        end
    end
`else
    assign load_s      = accept_s;
    assign load_word_s = padded_s;
`endif

    // Next-state and shift/index control; a load wins over the last-byte return to IDLE.
    always_comb begin
        state_next_s = state_r;
        shift_next_s = shift_r;
        idx_next_s   = idx_r;
        if (load_s) begin
            state_next_s = SEND;
            shift_next_s = load_word_s;
            idx_next_s   = IDX_ZERO;
        end else if (tx_hs_s) begin
            shift_next_s = shift_r << 4'd8;
            if (last_s) begin
                state_next_s = IDLE;
                idx_next_s   = IDX_ZERO;
            end else begin
                state_next_s = SEND;
                idx_next_s   = idx_r + IDX_ONE;
            end
        end else begin
            state_next_s = state_r;
            shift_next_s = shift_r;
            idx_next_s   = idx_r;
        end
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= SHIFT_ZERO;
            idx_r      <= IDX_ZERO;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            shift_r    <= shift_next_s;
            idx_r      <= idx_next_s;
            tx_valid_r <= (state_next_s == SEND);
            busy_r     <= (state_next_s == SEND);
        end
    end

    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign tx_data  = shift_r[SHIFT_W-1 -: 8];

endmodule

// File: tb/tb_sink_byte_serializer.sv
// Directed bench for sink_byte_serializer: one instance per word width, inputs driven and outputs checked on the falling edge.
module tb_sink_byte_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic r12, v12, tr12, rdy12, tv12, b12;
    logic [11:0] d12;
    logic [7:0]  td12;
    logic r16, v16, tr16, rdy16, tv16, b16;
    logic [15:0] d16;
    logic [7:0]  td16;
    logic r24, v24, tr24, rdy24, tv24, b24;
    logic [23:0] d24;
    logic [7:0]  td24;
    logic r5, v5, tr5, rdy5, tv5, b5;
    logic [4:0]  d5;
    logic [7:0]  td5;
    logic r8, v8, tr8, rdy8, tv8, b8;
    logic [7:0]  d8;
    logic [7:0]  td8;

    sink_byte_serializer #(.SNK_WIDTH(12)) u12 (.clk(clk), .rst(r12), .snk_valid(v12), .snk_ready(rdy12),
        .snk(d12), .tx_ready(tr12), .tx_valid(tv12), .tx_data(td12), .busy(b12));
    sink_byte_serializer #(.SNK_WIDTH(16)) u16 (.clk(clk), .rst(r16), .snk_valid(v16), .snk_ready(rdy16),
        .snk(d16), .tx_ready(tr16), .tx_valid(tv16), .tx_data(td16), .busy(b16));
    sink_byte_serializer #(.SNK_WIDTH(24)) u24 (.clk(clk), .rst(r24), .snk_valid(v24), .snk_ready(rdy24),
        .snk(d24), .tx_ready(tr24), .tx_valid(tv24), .tx_data(td24), .busy(b24));
    sink_byte_serializer #(.SNK_WIDTH(5)) u5 (.clk(clk), .rst(r5), .snk_valid(v5), .snk_ready(rdy5),
        .snk(d5), .tx_ready(tr5), .tx_valid(tv5), .tx_data(td5), .busy(b5));
    sink_byte_serializer #(.SNK_WIDTH(8)) u8 (.clk(clk), .rst(r8), .snk_valid(v8), .snk_ready(rdy8),
        .snk(d8), .tx_ready(tr8), .tx_valid(tv8), .tx_data(td8), .busy(b8));

    // Byte handshakes seen on the 16-bit instance
    int hs16 = 0;
    always @(posedge clk) begin
        if (tv16 && tr16) hs16 <= hs16 + 1;
    end

    task automatic test_reset;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if ({tv12, b12, rdy12, td12} !== 11'h000) begin n_fail++; $display("FAIL reset_w12: got %h expected 000", {tv12, b12, rdy12, td12}); end
        n_checks++; if ({tv16, b16, rdy16, td16} !== 11'h000) begin n_fail++; $display("FAIL reset_w16: got %h expected 000", {tv16, b16, rdy16, td16}); end
        n_checks++; if ({tv24, b24, rdy24, td24} !== 11'h000) begin n_fail++; $display("FAIL reset_w24: got %h expected 000", {tv24, b24, rdy24, td24}); end
        n_checks++; if ({tv5, b5, rdy5, td5} !== 11'h000) begin n_fail++; $display("FAIL reset_w5: got %h expected 000", {tv5, b5, rdy5, td5}); end
        n_checks++; if ({tv8, b8, rdy8, td8} !== 11'h000) begin n_fail++; $display("FAIL reset_w8: got %h expected 000", {tv8, b8, rdy8, td8}); end
        @(negedge clk); r12 = 1'b0; r16 = 1'b0; r24 = 1'b0; r5 = 1'b0; r8 = 1'b0; #1;
        n_checks++; if ({rdy12, rdy16, rdy24, rdy5, rdy8} !== 5'b11111) begin n_fail++; $display("FAIL idle_ready: got %b expected 11111", {rdy12, rdy16, rdy24, rdy5, rdy8}); end
    endtask

    task automatic test_single_w12;
        @(negedge clk); v12 = 1'b1; d12 = 12'hABC; tr12 = 1'b1; #1;
        n_checks++; if (rdy12 !== 1'b1) begin n_fail++; $display("FAIL w12_accept_ready: got %b expected 1", rdy12); end
        @(negedge clk); v12 = 1'b0; d12 = 12'h555; #1;
        n_checks++; if ({tv12, b12, rdy12, td12} !== {3'b110, 8'h0A}) begin n_fail++; $display("FAIL w12_byte0: got %h expected %h", {tv12, b12, rdy12, td12}, {3'b110, 8'h0A}); end
        @(negedge clk); #1;
        n_checks++; if ({tv12, b12, rdy12, td12} !== {3'b111, 8'hBC}) begin n_fail++; $display("FAIL w12_byte1: got %h expected %h", {tv12, b12, rdy12, td12}, {3'b111, 8'hBC}); end
        @(negedge clk); #1;
        n_checks++; if ({tv12, b12} !== 2'b00) begin n_fail++; $display("FAIL w12_done: got %b expected 00", {tv12, b12}); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); v16 = 1'b1; d16 = 16'h1234; tr16 = 1'b1;
        @(negedge clk); d16 = 16'h5678; #1;
        n_checks++; if ({tv16, rdy16, td16} !== {2'b10, 8'h12}) begin n_fail++; $display("FAIL b2b_byte12: got %h expected %h", {tv16, rdy16, td16}, {2'b10, 8'h12}); end
        @(negedge clk); #1;
        n_checks++; if ({tv16, rdy16, td16} !== {2'b11, 8'h34}) begin n_fail++; $display("FAIL b2b_byte34: got %h expected %h", {tv16, rdy16, td16}, {2'b11, 8'h34}); end
        @(negedge clk); v16 = 1'b0; #1;
        n_checks++; if ({tv16, rdy16, td16} !== {2'b10, 8'h56}) begin n_fail++; $display("FAIL b2b_byte56: got %h expected %h", {tv16, rdy16, td16}, {2'b10, 8'h56}); end
        @(negedge clk); #1;
        n_checks++; if ({tv16, rdy16, td16} !== {2'b11, 8'h78}) begin n_fail++; $display("FAIL b2b_byte78: got %h expected %h", {tv16, rdy16, td16}, {2'b11, 8'h78}); end
        @(negedge clk); #1;
        n_checks++; if ({tv16, b16} !== 2'b00) begin n_fail++; $display("FAIL b2b_done: got %b expected 00", {tv16, b16}); end
    endtask

    task automatic test_stall;
        int hs_start;
        hs_start = hs16;
        @(negedge clk); v16 = 1'b1; d16 = 16'hBEEF; tr16 = 1'b1;
        @(negedge clk); v16 = 1'b0; #1;
        n_checks++; if ({tv16, td16} !== {1'b1, 8'hBE}) begin n_fail++; $display("FAIL stall_byteBE: got %h expected %h", {tv16, td16}, {1'b1, 8'hBE}); end
        @(negedge clk); tr16 = 1'b0; #1;
        n_checks++; if ({tv16, b16, td16} !== {2'b11, 8'hEF}) begin n_fail++; $display("FAIL stall_hold1: got %h expected %h", {tv16, b16, td16}, {2'b11, 8'hEF}); end
        @(negedge clk); #1;
        n_checks++; if ({tv16, b16, td16} !== {2'b11, 8'hEF}) begin n_fail++; $display("FAIL stall_hold2: got %h expected %h", {tv16, b16, td16}, {2'b11, 8'hEF}); end
        @(negedge clk); tr16 = 1'b1; #1;
        n_checks++; if ({tv16, td16} !== {1'b1, 8'hEF}) begin n_fail++; $display("FAIL stall_release: got %h expected %h", {tv16, td16}, {1'b1, 8'hEF}); end
        @(negedge clk); #1;
        n_checks++; if (tv16 !== 1'b0) begin n_fail++; $display("FAIL stall_done: got %b expected 0", tv16); end
        n_checks++; if ((hs16 - hs_start) !== 2) begin n_fail++; $display("FAIL stall_handshakes: got %0d expected 2", hs16 - hs_start); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'h01;
        @(negedge clk); v24 = 1'b1; d24 = 24'hC0FFEE; tr24 = 1'b1;
        @(negedge clk); v24 = 1'b0; #1;
        n_checks++; if ({tv24, td24} !== {1'b1, 8'hC0}) begin n_fail++; $display("FAIL rst24_byteC0: got %h expected %h", {tv24, td24}, {1'b1, 8'hC0}); end
        @(negedge clk); r24 = 1'b1; #1;
        n_checks++; if ({tv24, td24} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL rst24_byteFF: got %h expected %h", {tv24, td24}, {1'b1, 8'hFF}); end
        @(negedge clk); #1;
        n_checks++; if ({tv24, b24, rdy24, td24} !== 11'h000) begin n_fail++; $display("FAIL rst24_cleared: got %h expected 000", {tv24, b24, rdy24, td24}); end
        @(negedge clk); r24 = 1'b0; v24 = 1'b1; d24 = 24'h000001; #1;
        n_checks++; if ({tv24, rdy24} !== 2'b01) begin n_fail++; $display("FAIL rst24_idle: got %b expected 01", {tv24, rdy24}); end
        @(negedge clk); v24 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++; if ({tv24, td24} !== {1'b1, exp_b[i]}) begin n_fail++; $display("FAIL rst24_next_byte%0d: got %h expected %h", i, {tv24, td24}, {1'b1, exp_b[i]}); end
        end
        @(negedge clk); #1;
        n_checks++; if (tv24 !== 1'b0) begin n_fail++; $display("FAIL rst24_no_stale: got %b expected 0", tv24); end
    endtask

    task automatic test_one_byte;
        logic [4:0] w [3];
        w[0] = 5'h11; w[1] = 5'h0A; w[2] = 5'h15;
        @(negedge clk); v5 = 1'b1; d5 = 5'h1F; tr5 = 1'b1;
        @(negedge clk); v5 = 1'b0; #1;
        n_checks++; if ({tv5, b5, rdy5, td5} !== {3'b111, 8'h1F}) begin n_fail++; $display("FAIL w5_single: got %h expected %h", {tv5, b5, rdy5, td5}, {3'b111, 8'h1F}); end
        @(negedge clk); #1;
        n_checks++; if (tv5 !== 1'b0) begin n_fail++; $display("FAIL w5_single_done: got %b expected 0", tv5); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); v5 = 1'b1; d5 = w[i]; #1;
            if (i > 0) begin
                n_checks++; if ({tv5, rdy5, td5} !== {2'b11, 3'b000, w[i-1]}) begin n_fail++; $display("FAIL w5_stream%0d: got %h expected %h", i - 1, {tv5, rdy5, td5}, {2'b11, 3'b000, w[i-1]}); end
            end
        end
        @(negedge clk); v5 = 1'b0; #1;
        n_checks++; if ({tv5, rdy5, td5} !== {2'b11, 3'b000, w[2]}) begin n_fail++; $display("FAIL w5_stream2: got %h expected %h", {tv5, rdy5, td5}, {2'b11, 3'b000, w[2]}); end
        @(negedge clk); #1;
        n_checks++; if (tv5 !== 1'b0) begin n_fail++; $display("FAIL w5_stream_done: got %b expected 0", tv5); end
    endtask

`ifdef SINK_ZERO_SKIP_EN
    task automatic test_zero_skip;
        tr8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); v8 = 1'b1; d8 = 8'h00; #1;
            n_checks++; if ({tv8, rdy8} !== 2'b01) begin n_fail++; $display("FAIL zs_skip%0d: got %b expected 01", i, {tv8, rdy8}); end
        end
        @(negedge clk); d8 = 8'h2A; #1;
        n_checks++; if (tv8 !== 1'b0) begin n_fail++; $display("FAIL zs_idle: got %b expected 0", tv8); end
        @(negedge clk); v8 = 1'b0; #1;
        n_checks++; if ({tv8, rdy8, td8} !== {2'b10, 8'h03}) begin n_fail++; $display("FAIL zs_prefix03: got %h expected %h", {tv8, rdy8, td8}, {2'b10, 8'h03}); end
        @(negedge clk); #1;
        n_checks++; if ({tv8, rdy8, td8} !== {2'b11, 8'h2A}) begin n_fail++; $display("FAIL zs_payload2A: got %h expected %h", {tv8, rdy8, td8}, {2'b11, 8'h2A}); end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); v8 = 1'b1; d8 = 8'h00; #1;
            n_checks++; if (tv8 !== 1'b0) begin n_fail++; $display("FAIL zs_zero%0d: got %b expected 0", i, tv8); end
        end
        @(negedge clk); v8 = 1'b0; #1;
        n_checks++; if ({tv8, b8, td8} !== {2'b11, 8'hFF}) begin n_fail++; $display("FAIL zs_prefixFF: got %h expected %h", {tv8, b8, td8}, {2'b11, 8'hFF}); end
        @(negedge clk); #1;
        n_checks++; if ({tv8, td8} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL zs_payload00: got %h expected %h", {tv8, td8}, {1'b1, 8'h00}); end
        @(negedge clk); v8 = 1'b1; d8 = 8'h01; #1;
        n_checks++; if (tv8 !== 1'b0) begin n_fail++; $display("FAIL zs_idle2: got %b expected 0", tv8); end
        @(negedge clk); v8 = 1'b0; #1;
        n_checks++; if ({tv8, td8} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL zs_prefix00: got %h expected %h", {tv8, td8}, {1'b1, 8'h00}); end
        @(negedge clk); #1;
        n_checks++; if ({tv8, td8} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL zs_payload01: got %h expected %h", {tv8, td8}, {1'b1, 8'h01}); end
        @(negedge clk); #1;
        n_checks++; if (tv8 !== 1'b0) begin n_fail++; $display("FAIL zs_done: got %b expected 0", tv8); end
    endtask
`else
    task automatic test_w8_plain;
        @(negedge clk); v8 = 1'b1; d8 = 8'hA5; tr8 = 1'b1;
        @(negedge clk); v8 = 1'b0; #1;
        n_checks++; if ({tv8, b8, td8} !== {2'b11, 8'hA5}) begin n_fail++; $display("FAIL w8_byteA5: got %h expected %h", {tv8, b8, td8}, {2'b11, 8'hA5}); end
        @(negedge clk); #1;
        n_checks++; if ({tv8, b8} !== 2'b00) begin n_fail++; $display("FAIL w8_done: got %b expected 00", {tv8, b8}); end
    endtask
`endif

    initial begin
        r12 = 1'b1; v12 = 1'b0; d12 = 12'h000; tr12 = 1'b1;
        r16 = 1'b1; v16 = 1'b0; d16 = 16'h0000; tr16 = 1'b1;
        r24 = 1'b1; v24 = 1'b0; d24 = 24'h000000; tr24 = 1'b1;
        r5 = 1'b1; v5 = 1'b0; d5 = 5'h00; tr5 = 1'b1;
        r8 = 1'b1; v8 = 1'b0; d8 = 8'h00; tr8 = 1'b1;
        test_reset();
`ifdef SINK_ZERO_SKIP_EN
        test_zero_skip();
`else
        test_single_w12();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_one_byte();
        test_w8_plain();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
